bottle_fill_ctrl: RTL

- Consumer side of the max-count setting: reads the latched two-digit BCD limit (maxL/maxH) and runs the filling of one bottle.
- Counts pill-sensor pulses in BCD and holds the feed valve open until the count reaches the limit.
- Then flags the bottle full and waits for a bottle-change acknowledge before starting the next bottle.
- Sits between the setting register, the pill sensor and the valve/display logic.

---
 rtl/bottle_fill_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/bottle_fill_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : bottle_fill_ctrl                                            |
// | Purpose  : Fills one bottle: counts synchronized pill pulses in BCD up |
// |            to the live maxH/maxL limit, then waits for bottle change.  |
// | Option   : define BOTTLE_TOTAL_EN to add the totH/totL bottle counter. |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module bottle_fill_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN_work,
  input  logic       EN_set,
  input  logic       pill,
  input  logic       bottle_ack,
  input  logic [3:0] maxL,
  input  logic [3:0] maxH,
  output logic [3:0] cntL,
  output logic [3:0] cntH,
  output logic       valve,
  output logic       full,
  output logic [1:0] state
`ifdef BOTTLE_TOTAL_EN
  ,
  output logic [3:0] totL,
  output logic [3:0] totH
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_FILL = 2'b01,
    ST_FULL = 2'b10
  } state_t;

  state_t                 r_state;
  logic [3:0]             r_cnt_l;
  logic [3:0]             r_cnt_h;
  logic                   r_valve;
  logic                   r_full;
  logic [SYNC_STAGES-1:0] r_pill_sync;
  logic [SYNC_STAGES-1:0] r_ack_sync;
  logic                   r_pill_d;
  logic                   r_ack_d;

  logic       w_pill_ev;
  logic       w_ack_ev;
  logic [3:0] w_lim_l;
  logic [3:0] w_lim_h;
  logic [6:0] w_lim;
  logic [6:0] w_cnt;
  logic [6:0] w_inc_val;
  logic [3:0] w_inc_l;
  logic [3:0] w_inc_h;
  logic       w_at_max;
  logic       w_go;
  logic       w_exit;
  logic       w_pill_inc;
  logic       w_to_full;

  // Both raw inputs are asynchronous: shift through SYNC_STAGES flops, then edge-detect
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pill_sync <= '0;
      r_ack_sync  <= '0;
      r_pill_d    <= 1'b0;
      r_ack_d     <= 1'b0;
    end else begin
      r_pill_sync <= {r_pill_sync[SYNC_STAGES-2:0], pill};
      r_ack_sync  <= {r_ack_sync[SYNC_STAGES-2:0], bottle_ack};
      r_pill_d    <= r_pill_sync[SYNC_STAGES-1];
      r_ack_d     <= r_ack_sync[SYNC_STAGES-1];
    end
  end

  assign w_pill_ev = r_pill_sync[SYNC_STAGES-1] & ~r_pill_d;
  assign w_ack_ev  = r_ack_sync[SYNC_STAGES-1] & ~r_ack_d;

  assign w_lim_l   = (maxL > 4'd9) ? 4'd9 : maxL;
  assign w_lim_h   = (maxH > 4'd9) ? 4'd9 : maxH;
  assign w_lim     = {3'b000, w_lim_h} * 7'd10 + {3'b000, w_lim_l};
  assign w_cnt     = {3'b000, r_cnt_h} * 7'd10 + {3'b000, r_cnt_l};
  assign w_inc_val = w_cnt + 7'd1;
  assign w_at_max  = (w_cnt == 7'd99);

  assign w_inc_l = (r_cnt_l == 4'd9) ? 4'd0 : r_cnt_l + 4'd1;
  assign w_inc_h = (r_cnt_l == 4'd9) ? r_cnt_h + 4'd1 : r_cnt_h;

  assign w_go   = EN_work & ~EN_set & (w_lim != 7'd0);
  assign w_exit = ~EN_work | EN_set;

  // A limit already met (lowered mid-fill, or resumed count) finishes without counting
  assign w_pill_inc = w_pill_ev & ~w_at_max & (w_cnt < w_lim);
  assign w_to_full  = (r_state == ST_FILL) & ~w_exit &
                      ((w_cnt >= w_lim) | (w_pill_inc & (w_inc_val >= w_lim)));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_cnt_l <= 4'd0;
      r_cnt_h <= 4'd0;
      r_valve <= 1'b0;
      r_full  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_valve <= 1'b0;
          r_full  <= 1'b0;
          if (w_go) begin
            r_state <= ST_FILL;
            r_valve <= 1'b1;
          end
        end
        ST_FILL: begin
          if (w_exit) begin
            r_state <= ST_IDLE;
            r_valve <= 1'b0;
          end else begin
            if (w_pill_inc) begin
              r_cnt_l <= w_inc_l;
              r_cnt_h <= w_inc_h;
            end
            if (w_to_full) begin
              r_state <= ST_FULL;
              r_valve <= 1'b0;
              r_full  <= 1'b1;
            end
          end
        end
        ST_FULL: begin
          r_valve <= 1'b0;
          if (w_exit) begin
            r_state <= ST_IDLE;
            r_full  <= 1'b0;
          end else if (w_ack_ev) begin
            r_cnt_l <= 4'd0;
            r_cnt_h <= 4'd0;
            r_full  <= 1'b0;
            if (w_go) begin
              r_state <= ST_FILL;
              r_valve <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_valve <= 1'b0;
          r_full  <= 1'b0;
        end
      endcase
    end
  end

`ifdef BOTTLE_TOTAL_EN
  logic [3:0] r_tot_l;
  logic [3:0] r_tot_h;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_tot_l <= 4'd0;
      r_tot_h <= 4'd0;
    end else if (w_to_full) begin
      if (r_tot_l == 4'd9) begin
        r_tot_l <= 4'd0;
        r_tot_h <= (r_tot_h == 4'd9) ? 4'd0 : r_tot_h + 4'd1;
      end else begin
        r_tot_l <= r_tot_l + 4'd1;
      end
    end
  end

  assign totL = r_tot_l;
  assign totH = r_tot_h;
`endif

  assign cntL  = r_cnt_l;
  assign cntH  = r_cnt_h;
  assign valve = r_valve;
  assign full  = r_full;
  assign state = r_state;

endmodule
`default_nettype wire
